rover_turn_sequencer: RTL and testbench
=======================================

Name: rover_turn_sequencer

Overview:
Command sequencer that drives the rover_sensors motor/turn block.
- Accepts a queue of 2-bit turn-procedure codes and issues them one at a time on enable_motor/turn_procedure.
- Waits for done_turning after each command, then brakes for a settle interval before issuing the next.
- Supervises each command with a watchdog timeout, a pause (hold) input and an abort input.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 100_000_000, max CLK cycles a command may stay in RUN (excluding held cycles) before fault
SETTLE_CYCLES, 1000, cycles enable_motor is held low between consecutive commands

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command push request
cmd_code  in  2  turn procedure code to enqueue
cmd_ready  out  1  FIFO not full; push occurs on cmd_valid & cmd_ready
start  in  1  begin executing the queue (level or pulse; sampled in IDLE only)
hold  in  1  pause current command
abort  in  1  flush queue, stop motors, clear fault
done_turning  in  1  completion flag from rover_sensors
enable_motor  out  1  to rover_sensors
turn_procedure  out  2  to rover_sensors; stable for the whole command
busy  out  1  state is not IDLE
fault  out  1  watchdog expired
queue_count  out  $clog2(DEPTH+1)  entries in FIFO
cmds_done  out  8  completed-command counter, saturates at 255

Behaviour:
Reset (RST_N low, asynchronous):
- state=IDLE, FIFO empty, enable_motor=0, turn_procedure=0, busy=0, fault=0, cmds_done=0.
- queue_count=0, cmd_ready=1, done_prev=0.

Outputs:
- All outputs are registered except cmd_ready (= !full) and queue_count.

FIFO:
- Pushes are accepted in any state except during an abort cycle; abort wins over a same-cycle push, and that push is dropped.
- Full: cmd_ready=0 and pushes are ignored.
- Pop and push in the same cycle are both legal when not full; count is unchanged.
- Pointers wrap modulo DEPTH.

Done detection:
- done_prev registers done_turning.
- done_rise = done_turning & !done_prev. Only a rising edge completes a command, so a stale high level at entry to RUN is ignored.

FSM states:
- IDLE: enable_motor=0. If start & queue_count!=0, go to ISSUE.
- ISSUE (1 cycle): pop head into turn_procedure, clear timer, go to RUN. Latency from start to enable_motor=1 is 2 cycles.
- RUN:
  - enable_motor = !hold.
  - While hold=1, the timer is frozen and done_rise is ignored.
  - If done_rise & !hold: enable_motor=0, cmds_done+=1 (saturating), clear timer, go to SETTLE.
  - Else if timer reaches TIMEOUT_CYCLES-1: go to FAULT.
  - If done_rise and the timeout occur in the same cycle, done wins.
- SETTLE: enable_motor=0. After SETTLE_CYCLES cycles, go to ISSUE if the queue is non-empty, else IDLE. start is not needed to continue.
- FAULT: enable_motor=0, fault=1. Stays until abort. The queue is retained until the abort flushes it.

Abort (any state):
- On the next edge: enable_motor=0, FIFO flushed, fault=0, state=IDLE.
- turn_procedure holds its last value.
- cmds_done is not cleared.

Other rules:
- Timer width is $clog2(TIMEOUT_CYCLES+1) bits; it never wraps (it is bounded by the FSM).
- A reset mid-command drops everything immediately, with no settle phase.

Decomposition:
Shared package (rover_pkg):
- FSM state encoding (IDLE, ISSUE, RUN, SETTLE, FAULT).
- Turn-code constants shared with rover_sensors (2-bit procedure codes).
- Default timing constants.

One natural sub-module: rover_cmd_fifo.
- Parameter DEPTH, width 2.
- Ports: push/pop/flush, full/empty/count.
- The FSM, timers, edge detection and counter stay in the top.

Test Plan:
All tests use DEPTH=4, TIMEOUT_CYCLES=50, SETTLE_CYCLES=4.
1. Push codes 1,2 then pulse start; pulse done_turning 10 cycles after each enable -> enable_motor high 2 cycles after start with turn_procedure=1; low 4 cycles; high with turn_procedure=2; then IDLE; cmds_done=2; queue_count=0.
2. Push 5 commands back-to-back while IDLE -> cmd_ready=0 after the 4th; the 5th is dropped; queue_count=4.
3. Start one command and never assert done_turning -> fault=1 and enable_motor=0 after 50 RUN cycles; abort -> fault=0, IDLE, queue empty.
4. During RUN assert hold for 100 cycles, with a done pulse inside the hold window -> enable_motor=0 during hold; no fault; done ignored; after release a new done completes the command.
5. done_turning already high when RUN is entered -> not counted until it falls and rises again; cmds_done increments only once.
6. Assert RST_N low mid-RUN (asynchronous, between edges) -> enable_motor=0 and queue_count=0 immediately; the abort-same-cycle-as-push case drops the push.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared definitions for the rover turn sequencer.
// State encoding, turn codes and timing defaults.
package rover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_t;

  localparam logic [1:0] TURN_STRAIGHT = 2'd0;
  localparam logic [1:0] TURN_LEFT     = 2'd1;
  localparam logic [1:0] TURN_RIGHT    = 2'd2;
  localparam logic [1:0] TURN_SPIN     = 2'd3;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 100_000_000;
  localparam int DEF_SETTLE  = 1000;

endpackage

// File: rtl/rover_cmd_fifo.sv
// Small command queue for 2-bit turn codes.
// Flush has priority over push and pop.
module rover_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [1:0]                 i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [1:0]                 o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  // Storage write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rover_turn_sequencer.sv
// Issues queued turn codes to rover_sensors one at a time,
// with watchdog, hold, abort and a settle gap between commands.
module rover_turn_sequencer
  import rover_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int SETTLE_CYCLES  = DEF_SETTLE
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_code,
  output logic                       cmd_ready,
  input  logic                       start,
  input  logic                       hold,
  input  logic                       abort,
  input  logic                       done_turning,
  output logic                       enable_motor,
  output logic [1:0]                 turn_procedure,
  output logic                       busy,
  output logic                       fault,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic [7:0]                 cmds_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  // The ISSUE cycle is the last low cycle of the gap,
  // so SETTLE itself lasts one cycle less.
  localparam logic [SW-1:0] SET_LAST =
    SW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);

  seq_state_t    r_state;
  logic          r_en;
  logic [1:0]    r_tp;
  logic          r_busy;
  logic          r_fault;
  logic [7:0]    r_cmds;
  logic          r_done_prev;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_settle;

  logic          w_full;
  logic          w_empty;
  logic [1:0]    w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_done_rise;

  assign w_push      = cmd_valid && !abort;
  assign w_pop       = (r_state == ST_ISSUE) && !abort;
  assign w_done_rise = done_turning && !r_done_prev;

  rover_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_data  (cmd_code),
    .i_pop   (w_pop),
    .i_flush (abort),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (queue_count)
  );

  assign cmd_ready      = !w_full;
  assign enable_motor   = r_en;
  assign turn_procedure = r_tp;
  assign busy           = r_busy;
  assign fault          = r_fault;
  assign cmds_done      = r_cmds;

  // Command FSM with registered outputs, timers and done edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_en        <= 1'b0;
      r_tp        <= TURN_STRAIGHT;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_cmds      <= '0;
      r_done_prev <= 1'b0;
      r_timer     <= '0;
      r_settle    <= '0;
    end else begin
      r_done_prev <= done_turning;
      if (abort) begin
        r_state <= ST_IDLE;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
        r_fault <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_en <= 1'b0;
            if (start && !w_empty) begin
              r_state <= ST_ISSUE;
              r_busy  <= 1'b1;
            end
          end
          ST_ISSUE: begin
            r_tp    <= w_head;
            r_timer <= '0;
            r_en    <= !hold;
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (hold) begin
              r_en <= 1'b0;
            end else if (w_done_rise) begin
              r_en     <= 1'b0;
              r_timer  <= '0;
              r_settle <= '0;
              r_state  <= ST_SETTLE;
              if (r_cmds != 8'hFF) r_cmds <= r_cmds + 8'd1;
            end else if (r_timer == TO_LAST) begin
              r_en    <= 1'b0;
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end else begin
              r_en    <= 1'b1;
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_SETTLE: begin
            r_en <= 1'b0;
            if (r_settle == SET_LAST) begin
              if (!w_empty) begin
                r_state <= ST_ISSUE;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          ST_FAULT: begin
            r_en    <= 1'b0;
            r_fault <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rover_turn_sequencer.sv
// Self-checking bench for rover_turn_sequencer.
// Directed sequences, a vector table and random traffic vs a model.
module tb_rover_turn_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 50;
  localparam int SET   = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic       start;
  logic       hold;
  logic       abort;
  logic       done_turning;
  logic       enable_motor;
  logic [1:0] turn_procedure;
  logic       busy;
  logic       fault;
  logic [2:0] queue_count;
  logic [7:0] cmds_done;

  rover_turn_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .SETTLE_CYCLES  (SET)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .cmd_ready      (cmd_ready),
    .start          (start),
    .hold           (hold),
    .abort          (abort),
    .done_turning   (done_turning),
    .enable_motor   (enable_motor),
    .turn_procedure (turn_procedure),
    .busy           (busy),
    .fault          (fault),
    .queue_count    (queue_count),
    .cmds_done      (cmds_done)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: phases of a command's life.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_RUN = 2;
  localparam int P_SETTLE = 3, P_FAULT = 4;

  int q[$];
  int m_ph, m_tp, m_done, m_act, m_low;
  bit m_en, m_busy, m_fault, m_dprev;

  function automatic void model_reset();
    q.delete();
    m_ph = P_IDLE; m_tp = 0; m_done = 0;
    m_act = 0; m_low = 0;
    m_en = 0; m_busy = 0; m_fault = 0; m_dprev = 0;
  endfunction

  function automatic void model_edge();
    bit rise;
    bit psh;
    rise = done_turning && !m_dprev;
    m_dprev = done_turning;
    if (abort) begin
      q.delete();
      m_ph = P_IDLE; m_en = 0; m_fault = 0; m_busy = 0;
      return;
    end
    psh = cmd_valid && (q.size() < DEPTH);
    case (m_ph)
      P_IDLE:
        if (start && q.size() != 0) begin
          m_ph = P_ISSUE; m_busy = 1;
        end
      P_ISSUE: begin
        m_tp = q.pop_front();
        m_act = 0; m_en = !hold; m_ph = P_RUN;
      end
      P_RUN:
        if (hold) m_en = 0;
        else if (rise) begin
          m_en = 0; m_low = 1; m_ph = P_SETTLE;
          if (m_done < 255) m_done++;
        end else if (m_act == TO - 1) begin
          m_en = 0; m_fault = 1; m_ph = P_FAULT;
        end else begin
          m_en = 1; m_act++;
        end
      P_SETTLE:
        if (m_low >= SET - 1) begin
          if (q.size() != 0) m_ph = P_ISSUE;
          else begin m_ph = P_IDLE; m_busy = 0; end
        end else m_low++;
      default: ;
    endcase
    if (psh) q.push_back(int'(cmd_code));
  endfunction

  task automatic compare_all();
    chk("m_cmd_ready", cmd_ready, q.size() < DEPTH);
    chk("m_queue_count", queue_count, q.size());
    chk("m_enable_motor", enable_motor, m_en);
    chk("m_turn_procedure", turn_procedure, m_tp);
    chk("m_busy", busy, m_busy);
    chk("m_fault", fault, m_fault);
    chk("m_cmds_done", cmds_done, m_done);
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_code = 0; start = 0;
    hold = 0; abort = 0; done_turning = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    chk("rst_enable", enable_motor, 0);
    chk("rst_tp", turn_procedure, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cmds_done", cmds_done, 0);
    chk("rst_queue_count", queue_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    RST_N = 1;
  endtask

  task automatic push1(int code);
    cmd_valid = 1; cmd_code = 2'(code);
    cyc();
    cmd_valid = 0;
  endtask

  typedef struct {
    bit       v;
    bit [1:0] c;
    bit       ab;
    bit       rdy;
    int       qc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{1, 2'd1, 0, 1, 1};
    tbl[1] = '{1, 2'd2, 0, 1, 2};
    tbl[2] = '{1, 2'd3, 0, 1, 3};
    tbl[3] = '{1, 2'd0, 0, 0, 4};
    tbl[4] = '{1, 2'd3, 0, 0, 4};
    tbl[5] = '{1, 2'd2, 1, 1, 0};
    tbl[6] = '{0, 2'd0, 0, 1, 0};

    // Two commands, settle gap, completion count.
    do_reset();
    push1(1);
    push1(2);
    start = 1;
    cyc();
    start = 0;
    chk("t1_issue_en", enable_motor, 0);
    chk("t1_issue_busy", busy, 1);
    cyc();
    chk("t1_en_latency", enable_motor, 1);
    chk("t1_tp1", turn_procedure, 1);
    repeat (9) cyc();
    done_turning = 1;
    cyc();
    done_turning = 0;
    chk("t1_en_off", enable_motor, 0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (enable_motor) break;
      n++;
    end
    chk("t1_low_cycles", n, SET);
    chk("t1_tp2", turn_procedure, 2);
    repeat (9) cyc();
    done_turning = 1;
    cyc();
    done_turning = 0;
    for (int i = 0; i < 20 && busy; i++) cyc();
    chk("t1_idle", busy, 0);
    chk("t1_cmds_done", cmds_done, 2);
    chk("t1_queue_empty", queue_count, 0);

    // Fill table, overflow drop, abort beats push.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cmd_valid = tbl[i].v;
      cmd_code  = tbl[i].c;
      abort     = tbl[i].ab;
      cyc();
      chk($sformatf("t2_ready_%0d", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("t2_count_%0d", i), queue_count, tbl[i].qc);
    end
    idle_inputs();

    // Watchdog fault, queue retained, abort clears.
    do_reset();
    push1(3);
    push1(2);
    start = 1;
    cyc();
    start = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (fault) break;
      if (enable_motor) n++;
    end
    chk("t3_run_cycles", n, TO);
    chk("t3_fault", fault, 1);
    chk("t3_en_off", enable_motor, 0);
    chk("t3_queue_kept", queue_count, 1);
    abort = 1;
    cyc();
    abort = 0;
    chk("t3_fault_clr", fault, 0);
    chk("t3_idle", busy, 0);
    chk("t3_flushed", queue_count, 0);

    // Long hold freezes watchdog and masks done.
    do_reset();
    push1(2);
    start = 1;
    cyc();
    start = 0;
    repeat (3) cyc();
    hold = 1;
    for (int i = 0; i < 100; i++) begin
      done_turning = (i == 50);
      cyc();
      chk("t4_hold_en", enable_motor, 0);
      chk("t4_hold_fault", fault, 0);
    end
    hold = 0;
    done_turning = 0;
    repeat (3) cyc();
    chk("t4_resume_en", enable_motor, 1);
    chk("t4_done_ignored", cmds_done, 0);
    done_turning = 1;
    cyc();
    done_turning = 0;
    chk("t4_complete_en", enable_motor, 0);
    chk("t4_cmds_done", cmds_done, 1);
    repeat (6) cyc();

    // Stale high done at RUN entry is not a completion.
    do_reset();
    push1(1);
    done_turning = 1;
    start = 1;
    cyc();
    start = 0;
    repeat (20) cyc();
    chk("t5_stale_en", enable_motor, 1);
    chk("t5_stale_cnt", cmds_done, 0);
    done_turning = 0;
    cyc();
    done_turning = 1;
    cyc();
    chk("t5_rise_en", enable_motor, 0);
    chk("t5_rise_cnt", cmds_done, 1);
    repeat (10) cyc();
    chk("t5_once_cnt", cmds_done, 1);
    chk("t5_idle", busy, 0);
    done_turning = 0;

    // Asynchronous reset in the middle of RUN.
    do_reset();
    push1(1);
    push1(2);
    push1(3);
    start = 1;
    cyc();
    start = 0;
    repeat (3) cyc();
    chk("t6_running", enable_motor, 1);
    #2;
    RST_N = 0;
    #1;
    chk("t6_async_en", enable_motor, 0);
    chk("t6_async_qc", queue_count, 0);
    chk("t6_async_busy", busy, 0);
    model_reset();
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1;
    cyc();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_code  = 2'($urandom_range(0, 3));
      start     = ($urandom_range(0, 5) == 0);
      hold      = ($urandom_range(0, 9) == 0);
      abort     = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0)
        done_turning = !done_turning;
      cyc();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
